// File: rtl/maxpool_2x2_ctrl.sv
// 2x2 max-pool controller: pairs pixels within a row, parks row maxima in a line FIFO.
// Optional `MAXPOOL_RELU_EN clamps negative pooled results to zero.
module maxpool_2x2_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] data_in,
  output logic                    fifo_rd_clr,
  output logic                    fifo_wr_clr,
  output logic                    fifo_rd_inc,
  output logic                    fifo_wr_inc,
  output logic                    fifo_rd_en,
  output logic                    fifo_wr_en,
  output logic [2*DATA_WIDTH-1:0] fifo_data_in,
  input  logic [2*DATA_WIDTH-1:0] fifo_data_out,
  output logic                    out_valid,
  output logic [2*DATA_WIDTH-1:0] data_out,
  output logic                    frame_done
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_DONE
  } state_t;

  state_t r_state;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  logic signed [PW-1:0] r_hold;
  logic signed [PW-1:0] r_hmax;
  logic signed [PW-1:0] r_pool;

  logic r_clr;
  logic r_p1;
  logic r_last1;
  logic r_ov;
  logic r_fd;

  logic signed [PW-1:0] w_din;
  logic signed [PW-1:0] w_fifo;
  logic signed [PW-1:0] w_hmax;
  logic signed [PW-1:0] w_vmax;
  logic signed [PW-1:0] w_pool;

  logic w_acc;
  logic w_odd_col;
  logic w_col_end;
  logic w_row_end;
  logic w_wr;
  logic w_rd;

  assign w_din  = data_in;
  assign w_fifo = fifo_data_out;

  assign w_acc = in_valid && !reset &&
                 ((r_state == S_EVEN) || (r_state == S_ODD));

  assign w_odd_col = r_col[0];
  assign w_col_end = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_end = (r_row == RW'(IMG_HEIGHT - 1));

  assign w_hmax = (w_din > r_hold) ? w_din : r_hold;
  assign w_vmax = (w_fifo > r_hmax) ? w_fifo : r_hmax;

`ifdef MAXPOOL_RELU_EN
  assign w_pool = w_vmax[PW-1] ? '0 : w_vmax;
`else
  assign w_pool = w_vmax;
`endif

  assign w_wr = w_acc && (r_state == S_EVEN) && w_odd_col;
  assign w_rd = w_acc && (r_state == S_ODD) && w_odd_col;

  assign fifo_wr_en   = w_wr;
  assign fifo_wr_inc  = w_wr;
  assign fifo_data_in = w_wr ? w_hmax : '0;
  assign fifo_rd_en   = w_rd;
  assign fifo_rd_inc  = w_rd;
  assign fifo_rd_clr  = r_clr || reset;
  assign fifo_wr_clr  = r_clr || reset;

  assign out_valid  = r_ov;
  assign data_out   = r_pool;
  assign frame_done = r_fd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_hold  <= '0;
      r_hmax  <= '0;
      r_pool  <= '0;
      r_clr   <= 1'b0;
      r_p1    <= 1'b0;
      r_last1 <= 1'b0;
      r_ov    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_clr   <= 1'b0;
      r_p1    <= w_rd;
      r_last1 <= w_rd && w_col_end && w_row_end;
      r_ov    <= r_p1;
      r_fd    <= r_p1 && r_last1;

      if (r_p1)
        r_pool <= w_pool;
      if (w_rd)
        r_hmax <= w_hmax;
      if (w_acc && !w_odd_col)
        r_hold <= w_din;

      if (w_acc) begin
        r_col <= w_col_end ? '0 : r_col + CW'(1);
        if (w_col_end)
          r_row <= w_row_end ? '0 : r_row + RW'(1);
      end

      // Row parity lives in the state; counters only track position.
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_EVEN;
            r_clr   <= 1'b1;
          end
        end
        S_EVEN: begin
          if (w_acc && w_col_end)
            r_state <= S_ODD;
        end
        S_ODD: begin
          if (w_acc && w_col_end) begin
            r_clr   <= 1'b1;
            r_state <= w_row_end ? S_DONE : S_EVEN;
          end
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_2x2_ctrl.sv
// Bench for maxpool_2x2_ctrl: 4x2 and 4x4 instances, line FIFO model, frame-level
// pooling model and per-cycle compare; honours `MAXPOOL_RELU_EN for expectations.
module tb_maxpool_2x2_ctrl;

  localparam int W = 4;

  logic clk;
  logic reset;
  logic start;
  logic in_valid;
  logic [15:0] data_in;
  logic sel;

  logic st   [2];
  logic rclr [2];
  logic wclr [2];
  logic rinc [2];
  logic winc [2];
  logic ren  [2];
  logic wen  [2];
  logic ov   [2];
  logic fd   [2];
  logic [15:0] fdin [2];
  logic [15:0] dout [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [2];
    logic        wp;
    logic        rp;
    logic [15:0] fdout;

    assign st[g] = start && (sel == (g == 1));

    maxpool_2x2_ctrl #(
      .DATA_WIDTH(8),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(g == 0 ? 2 : 4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (st[g]),
      .in_valid     (in_valid),
      .data_in      (data_in),
      .fifo_rd_clr  (rclr[g]),
      .fifo_wr_clr  (wclr[g]),
      .fifo_rd_inc  (rinc[g]),
      .fifo_wr_inc  (winc[g]),
      .fifo_rd_en   (ren[g]),
      .fifo_wr_en   (wen[g]),
      .fifo_data_in (fdin[g]),
      .fifo_data_out(fdout),
      .out_valid    (ov[g]),
      .data_out     (dout[g]),
      .frame_done   (fd[g])
    );

    always @(posedge clk) begin
      if (wclr[g]) wp <= 1'b0;
      else if (winc[g]) wp <= ~wp;
      if (wen[g]) mem[wp] <= fdin[g];
      if (rclr[g]) rp <= 1'b0;
      else if (rinc[g]) rp <= ~rp;
      if (ren[g]) fdout <= mem[rp];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    int          due;
    logic [15:0] val;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [15:0] got[$];
  int          fd_cnt;
  int          clr_cnt;

  logic signed [15:0] pix [4][W];
  logic [15:0] px [16];
  logic [15:0] last_out [2];
  logic        e_clr, e_wr, e_rd, clr_next;
  logic [15:0] e_wdata;
  int          phase, n;

  function automatic logic signed [15:0] max2(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] pool4(input int r, input int c);
    logic signed [15:0] m;
    m = max2(max2(pix[r-1][c-1], pix[r-1][c]), max2(pix[r][c-1], pix[r][c]));
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return m;
  endfunction

  function automatic logic [31:0] gv(input int i);
    return (i < got.size()) ? {16'h0, got[i]} : 32'hDEAD_BEEF;
  endfunction

  // One clock of stimulus plus the frame-level model's view of that cycle.
  task automatic step(input bit s, input bit v, input logic [15:0] d,
                      input bit rs);
    int r, c, h;
    @(posedge clk);
    #1;
    start    = s;
    in_valid = v;
    data_in  = d;
    reset    = rs;
    e_wr     = 1'b0;
    e_rd     = 1'b0;
    e_wdata  = '0;
    e_clr    = rs || clr_next;
    clr_next = 1'b0;
    h        = sel ? 4 : 2;
    if (rs) begin
      phase = 0;
      n     = 0;
      q.delete();
      last_out[0] = '0;
      last_out[1] = '0;
    end else begin
      case (phase)
        0: if (s) begin
          phase    = 1;
          n        = 0;
          clr_next = 1'b1;
        end
        1: if (v) begin
          r = n / W;
          c = n % W;
          pix[r][c] = d;
          if (c % 2 == 1) begin
            if (r % 2 == 0) begin
              e_wr    = 1'b1;
              e_wdata = max2(pix[r][c-1], pix[r][c]);
            end else begin
              e_rd = 1'b1;
              q.push_back('{cyc + 2, pool4(r, c), n == W * h - 1});
            end
          end
          if (r % 2 == 1 && c == W - 1) clr_next = 1'b1;
          n++;
          if (n == W * h) phase = 2;
        end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic frame(input int npx, input bit toggle);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < npx; i++) begin
      step(i == 2, 1'b1, px[i], 1'b0);
      if (toggle) step(1'b0, 1'b0, 16'h00AA, 1'b0);
    end
    repeat (5) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    int s;
    s = int'(sel);
    if (reset) begin
      chk("clr_in_reset", {30'h0, rclr[s], wclr[s]}, 32'h3);
      chk("en_in_reset", {28'h0, ren[s], rinc[s], wen[s], winc[s]}, 32'h0);
    end else begin
      chk("rd_clr", {31'h0, rclr[s]}, {31'h0, e_clr});
      chk("wr_clr", {31'h0, wclr[s]}, {31'h0, e_clr});
      chk("wr_en_inc", {30'h0, wen[s], winc[s]}, {30'h0, e_wr, e_wr});
      chk("fifo_data_in", {16'h0, fdin[s]}, {16'h0, e_wdata});
      chk("rd_en_inc", {30'h0, ren[s], rinc[s]}, {30'h0, e_rd, e_rd});
      if (rclr[s]) clr_cnt++;
      if (ov[s]) got.push_back(dout[s]);
      if (fd[s]) fd_cnt++;
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("out_valid", {31'h0, ov[s]}, 32'h1);
        chk("data_out", {16'h0, dout[s]}, {16'h0, q[0].val});
        chk("frame_done", {31'h0, fd[s]}, {31'h0, q[0].last});
        last_out[s] = q[0].val;
        void'(q.pop_front());
      end else begin
        chk("out_valid_idle", {31'h0, ov[s]}, 32'h0);
        chk("frame_done_idle", {31'h0, fd[s]}, 32'h0);
        chk("data_out_hold", {16'h0, dout[s]}, {16'h0, last_out[s]});
      end
    end
  end

  initial begin
    logic [15:0] neg_exp;
`ifdef MAXPOOL_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFFD;
`endif
    sel      = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    e_clr    = 1'b1;
    e_wr     = 1'b0;
    e_rd     = 1'b0;
    e_wdata  = '0;
    clr_next = 1'b0;
    phase    = 0;
    n        = 0;
    fd_cnt   = 0;
    clr_cnt  = 0;
    last_out[0] = '0;
    last_out[1] = '0;

    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_out_valid", {31'h0, ov[0]}, 32'h0);
    chk("rst_data_out", {16'h0, dout[0]}, 32'h0);
    chk("rst_frame_done", {31'h0, fd[0]}, 32'h0);
    step(1'b0, 1'b1, 16'd99, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);

    px[0] = 16'd1; px[1] = 16'd5; px[2] = 16'd3; px[3] = 16'd2;
    px[4] = 16'd4; px[5] = 16'd0; px[6] = 16'd9; px[7] = 16'd7;

    got.delete(); fd_cnt = 0;
    frame(8, 1'b0);
    chk("f1_count", got.size(), 2);
    chk("f1_first", gv(0), 5);
    chk("f1_second", gv(1), 9);
    chk("f1_done_cnt", fd_cnt, 1);

    got.delete(); fd_cnt = 0;
    frame(8, 1'b1);
    chk("tog_count", got.size(), 2);
    chk("tog_first", gv(0), 5);
    chk("tog_second", gv(1), 9);

    for (int i = 0; i < 8; i++) px[i] = 16'hFFFD;
    got.delete();
    frame(8, 1'b0);
    chk("neg_first", gv(0), {16'h0, neg_exp});
    chk("neg_second", gv(1), {16'h0, neg_exp});

    px[0] = 16'd1; px[1] = 16'd5; px[2] = 16'd3; px[3] = 16'd2;
    px[4] = 16'd4; px[5] = 16'd0; px[6] = 16'd9; px[7] = 16'd7;
    got.delete(); fd_cnt = 0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, px[i], 1'b0);
    repeat (3) step(1'b0, 1'b1, 16'd50, 1'b1);
    repeat (6) step(1'b0, 1'b1, 16'd60, 1'b0);
    chk("abort_no_out", got.size(), 0);
    chk("abort_no_done", fd_cnt, 0);
    frame(8, 1'b0);
    chk("after_abort_count", got.size(), 2);
    chk("after_abort_first", gv(0), 5);
    chk("after_abort_second", gv(1), 9);

    sel = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    px[8]  = 16'hFFFF; px[9]  = 16'hFFFE; px[10] = 16'd8; px[11] = 16'd6;
    px[12] = 16'd0;    px[13] = 16'hFFFB; px[14] = 16'd2; px[15] = 16'd10;
    got.delete(); fd_cnt = 0; clr_cnt = 0;
    frame(16, 1'b0);
    chk("h4_count", got.size(), 4);
    chk("h4_out0", gv(0), 5);
    chk("h4_out1", gv(1), 9);
    chk("h4_out2", gv(2), 0);
    chk("h4_out3", gv(3), 10);
    chk("h4_done_cnt", fd_cnt, 1);
    chk("h4_clr_pulses", clr_cnt, 3);
    chk("h4_queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/maxpool_2x2_ctrl.md
MAXPOOL_2X2_CTRL -- requirements
Module: maxpool_2x2_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the half-width of the pixel word; pixel words are 2*DATA_WIDTH bits, signed two's complement.
REQ-002 SHALL have parameter IMG_WIDTH, default 16, giving the input row length in pixels; even, and at most twice the attached line-FIFO depth.
REQ-003 SHALL have parameter IMG_HEIGHT, default 16, giving the input row count; even.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle frame-start pulse.
REQ-007 SHALL have port in_valid, input, 1 bit: data_in carries a pixel this cycle.
REQ-008 SHALL have port data_in, input, 2*DATA_WIDTH bits: conv output pixel, raster order.
REQ-009 SHALL have ports fifo_rd_clr, fifo_wr_clr, fifo_rd_inc, fifo_wr_inc, fifo_rd_en and fifo_wr_en, outputs, 1 bit each: line-FIFO pointer and enable controls.
REQ-010 SHALL have port fifo_data_in, output, 2*DATA_WIDTH bits: word written to the line FIFO.
REQ-011 SHALL have port fifo_data_out, input, 2*DATA_WIDTH bits: line-FIFO read word, valid one cycle after fifo_rd_en.
REQ-012 SHALL have ports out_valid, output, 1 bit, and data_out, output, 2*DATA_WIDTH bits: the pooled result.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-014 SHALL implement FSM IDLE -> EVEN_ROW on start; EVEN_ROW -> ODD_ROW after IMG_WIDTH accepted pixels; ODD_ROW -> EVEN_ROW after IMG_WIDTH pixels if rows remain, else -> DONE; DONE -> IDLE after one cycle.
REQ-015 SHALL accept pixels only when in_valid=1 in EVEN_ROW or ODD_ROW; in_valid in IDLE or DONE is ignored; start outside IDLE is ignored.
REQ-016 SHALL keep a column counter (0..IMG_WIDTH-1) and a row counter (0..IMG_HEIGHT-1), each advancing on accepted pixels and wrapping at row and frame end.
REQ-017 SHALL register the pixel at an even column into a hold register; at an odd column, hmax = signed max(hold, data_in).
REQ-018 SHALL, at an odd column in EVEN_ROW, drive fifo_wr_en=1, fifo_wr_inc=1 and fifo_data_in=hmax in the same cycle.
REQ-019 SHALL, at an odd column in ODD_ROW (cycle T), drive fifo_rd_en=1 and fifo_rd_inc=1 and register hmax; in T+1 it SHALL compute signed max(hmax_reg, fifo_data_out) and register it, so that out_valid=1 with data_out in T+2 (latency 2 cycles).
REQ-020 SHALL hold fifo_*_en/inc at 0 when not asserted per REQ-018/019; fifo_data_in SHALL be 0 when fifo_wr_en=0.
REQ-021 SHALL pulse fifo_rd_clr and fifo_wr_clr for one cycle on the IDLE->EVEN_ROW transition and in the cycle after the last pixel of every ODD_ROW.
REQ-022 SHALL sustain back-to-back in_valid with no bubbles; output rate is one pooled pixel per 2 accepted odd-row pixels.
REQ-023 SHALL assert frame_done in the same cycle as the final out_valid of the frame.
REQ-024 SHALL hold data_out at its last value when out_valid=0.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, enter IDLE, clear counters, the hold register and the pipeline, and drive out_valid=0, data_out=0, frame_done=0, all fifo enables and incs =0 and fifo_data_in=0.
REQ-026 SHALL drive fifo_rd_clr=1 and fifo_wr_clr=1 while reset=1; reset mid-frame SHALL abandon the frame with no further out_valid.

Configuration
REQ-027 SHALL, with macro MAXPOOL_RELU_EN defined, replace negative pooled results with 0 before registering data_out; without it, data_out SHALL be the raw signed max.

Verification
REQ-028 SHALL cover: IMG_WIDTH=4, IMG_HEIGHT=2, row0={1,5,3,2}, row1={4,0,9,7}, continuous valid -> out_valid carrying 5 then 9, the second concurrent with frame_done.
REQ-029 SHALL cover: same frame with in_valid toggling 1/0 -> identical outputs, each 2 cycles after the odd-column pixel.
REQ-030 SHALL cover: all pixels -3 (0xFFFD, DATA_WIDTH=8) -> data_out=0xFFFD without MAXPOOL_RELU_EN and 0x0000 with it.
REQ-031 SHALL cover: reset asserted after row0 column 2 -> out_valid never asserts, fifo clears held at 1, next start yields a correct frame.
REQ-032 SHALL cover: IMG_HEIGHT=4 frame -> fifo clear pulses after rows 1 and 3, 4 outputs, one frame_done.
